// File: rtl/drive_sequencer.sv
// Converts remote drive commands into per-wheel direction codes, inserting a
// coast interval before any reversal or stop and stopping on command silence.
module drive_sequencer #(
  parameter int DEAD_CYCLES = 50000,
  parameter int WDOG_CYCLES = 5000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  input  logic [3:0] cmd,
  output logic       cmd_ready,
  output logic [1:0] dir_l,
  output logic [1:0] dir_r,
  output logic       timeout,
  output logic       cmd_err
);

  localparam int DEAD_W = $clog2(DEAD_CYCLES) + 1;
  localparam int WDOG_W = $clog2(WDOG_CYCLES) + 1;
  localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEAD_CYCLES - 1);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DEAD} state_t;

  state_t            state_q, state_d;
  logic [1:0]        dir_l_q, dir_l_d, dir_r_q, dir_r_d;
  logic [1:0]        tgt_l_q, tgt_l_d, tgt_r_q, tgt_r_d;
  logic              ready_q, ready_d;
  logic              timeout_q, timeout_d;
  logic              cmd_err_q, cmd_err_d;
  logic [DEAD_W-1:0] dead_cnt_q, dead_cnt_d;
  logic [WDOG_W-1:0] wdog_cnt_q, wdog_cnt_d;

  logic       legal;
  logic [1:0] new_l, new_r;
  logic       accept;
  logic       leave;

  // Command decode; illegal codes fall back to stop on both wheels.
  always_comb begin
    legal = 1'b1;
    new_l = 2'b00;
    new_r = 2'b00;
    case (cmd)
      4'b1000: begin new_l = 2'b10; new_r = 2'b10; end
      4'b0100: begin new_l = 2'b01; new_r = 2'b01; end
      4'b0001: begin new_l = 2'b10; new_r = 2'b01; end
      4'b0010: begin new_l = 2'b01; new_r = 2'b10; end
      4'b1010: begin new_l = 2'b00; new_r = 2'b10; end
      4'b1001: begin new_l = 2'b10; new_r = 2'b00; end
      4'b0110: begin new_l = 2'b00; new_r = 2'b01; end
      4'b0101: begin new_l = 2'b01; new_r = 2'b00; end
      4'b0000: begin new_l = 2'b00; new_r = 2'b00; end
      default: legal = 1'b0;
    endcase
  end

  assign accept = cmd_valid & ready_q;
  assign leave  = ((dir_l_q != 2'b00) && (new_l != dir_l_q)) ||
                  ((dir_r_q != 2'b00) && (new_r != dir_r_q));

  always_comb begin
    state_d    = state_q;
    dir_l_d    = dir_l_q;
    dir_r_d    = dir_r_q;
    tgt_l_d    = tgt_l_q;
    tgt_r_d    = tgt_r_q;
    timeout_d  = 1'b0;
    cmd_err_d  = 1'b0;
    dead_cnt_d = '0;
    wdog_cnt_d = '0;
    case (state_q)
      IDLE, RUN: begin
        if (accept) begin
          cmd_err_d = ~legal;
          if (leave) begin
            tgt_l_d = new_l;
            tgt_r_d = new_r;
            dir_l_d = 2'b00;
            dir_r_d = 2'b00;
            state_d = DEAD;
          end else if (new_l == 2'b00 && new_r == 2'b00) begin
            dir_l_d = 2'b00;
            dir_r_d = 2'b00;
            state_d = IDLE;
          end else begin
            dir_l_d = new_l;
            dir_r_d = new_r;
            state_d = RUN;
          end
        end else if (state_q == RUN) begin
          // Counter reads k-1 in the k-th silent cycle, so expiry lands on the
          // cycle after WDOG_CYCLES-1 silent cycles.
          if (wdog_cnt_q + WDOG_W'(1) == WDOG_LAST) begin
            timeout_d = 1'b1;
            tgt_l_d   = 2'b00;
            tgt_r_d   = 2'b00;
            dir_l_d   = 2'b00;
            dir_r_d   = 2'b00;
            state_d   = DEAD;
          end else begin
            wdog_cnt_d = wdog_cnt_q + WDOG_W'(1);
          end
        end
      end
      DEAD: begin
        if (dead_cnt_q == DEAD_LAST) begin
          dir_l_d = tgt_l_q;
          dir_r_d = tgt_r_q;
          state_d = (tgt_l_q == 2'b00 && tgt_r_q == 2'b00) ? IDLE : RUN;
        end else begin
          dead_cnt_d = dead_cnt_q + DEAD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d != DEAD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      dir_l_q    <= 2'b00;
      dir_r_q    <= 2'b00;
      tgt_l_q    <= 2'b00;
      tgt_r_q    <= 2'b00;
      ready_q    <= 1'b1;
      timeout_q  <= 1'b0;
      cmd_err_q  <= 1'b0;
      dead_cnt_q <= '0;
      wdog_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      dir_l_q    <= dir_l_d;
      dir_r_q    <= dir_r_d;
      tgt_l_q    <= tgt_l_d;
      tgt_r_q    <= tgt_r_d;
      ready_q    <= ready_d;
      timeout_q  <= timeout_d;
      cmd_err_q  <= cmd_err_d;
      dead_cnt_q <= dead_cnt_d;
      wdog_cnt_q <= wdog_cnt_d;
    end
  end

  assign cmd_ready = ready_q;
  assign dir_l     = dir_l_q;
  assign dir_r     = dir_r_q;
  assign timeout   = timeout_q;
  assign cmd_err   = cmd_err_q;

endmodule

// File: tb/tb_drive_sequencer.sv
// Directed bench: each step pushes the hand-computed post-edge outputs into a
// queue; a monitor pops and compares them on the falling edge.
module tb_drive_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic [3:0] cmd;
  logic       cmd_ready;
  logic [1:0] dir_l, dir_r;
  logic       timeout, cmd_err;

  drive_sequencer #(.DEAD_CYCLES(4), .WDOG_CYCLES(20)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd(cmd),
    .cmd_ready(cmd_ready), .dir_l(dir_l), .dir_r(dir_r),
    .timeout(timeout), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] id;
    logic [6:0]  v;   // {dir_l, dir_r, ready, timeout, cmd_err}
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   step_id = 0;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [6:0] act;
      e   = exp_q.pop_front();
      act = {dir_l, dir_r, cmd_ready, timeout, cmd_err};
      total++;
      if (act !== e.v) begin
        bad++;
        $display("FAIL step%0d outputs: got %b want %b (dir_l dir_r rdy to err)",
                 e.id, act, e.v);
      end else begin
        $display("step%0d ok: %b", e.id, act);
      end
    end
  end

  // One cycle: drive inputs, take the edge, queue the expected post-edge outputs.
  task automatic step(input logic r, input logic v, input logic [3:0] c,
                      input logic [1:0] el, input logic [1:0] er,
                      input logic erdy, input logic eto, input logic eerr);
    exp_t e;
    rst = r; cmd_valid = v; cmd = c;
    @(posedge clk);
    #1;
    e.id = step_id;
    e.v  = {el, er, erdy, eto, eerr};
    exp_q.push_back(e);
    step_id++;
  endtask

  task automatic dead_cycles(input int n, input logic v, input logic [3:0] c);
    for (int i = 0; i < n; i++) step(0, v, c, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd = 4'b0000;
    // Reset state
    step(1, 0, 4'b0000, 2'b00, 2'b00, 1, 0, 0);
    step(1, 1, 4'b1000, 2'b00, 2'b00, 1, 0, 0);
    step(0, 0, 4'b0000, 2'b00, 2'b00, 1, 0, 0);
    // IDLE start forward
    step(0, 1, 4'b1000, 2'b10, 2'b10, 1, 0, 0);
    // Reverse with command held while not ready
    step(0, 1, 4'b0100, 2'b00, 2'b00, 0, 0, 0);
    dead_cycles(3, 1'b1, 4'b0100);
    step(0, 1, 4'b0100, 2'b01, 2'b01, 1, 0, 0);
    step(0, 0, 4'b0000, 2'b01, 2'b01, 1, 0, 0);
    // 01/01 -> 00/10 via coast
    step(0, 1, 4'b1010, 2'b00, 2'b00, 0, 0, 0);
    dead_cycles(3, 1'b0, 4'b0000);
    step(0, 0, 4'b0000, 2'b00, 2'b10, 1, 0, 0);
    // Adding motion to a stopped wheel: no coast
    step(0, 1, 4'b1000, 2'b10, 2'b10, 1, 0, 0);
    // Stopping the left wheel needs a coast
    step(0, 1, 4'b1010, 2'b00, 2'b00, 0, 0, 0);
    dead_cycles(3, 1'b0, 4'b0000);
    step(0, 0, 4'b0000, 2'b00, 2'b10, 1, 0, 0);
    // Spin: right wheel reverses
    step(0, 1, 4'b0001, 2'b00, 2'b00, 0, 0, 0);
    dead_cycles(3, 1'b0, 4'b0000);
    step(0, 0, 4'b0000, 2'b10, 2'b01, 1, 0, 0);
    // Re-send, then accept on the watchdog's last cycle prevents timeout
    step(0, 1, 4'b0001, 2'b10, 2'b01, 1, 0, 0);
    for (int i = 0; i < 18; i++) step(0, 0, 4'b0000, 2'b10, 2'b01, 1, 0, 0);
    step(0, 1, 4'b0001, 2'b10, 2'b01, 1, 0, 0);
    // Now 19 silent cycles -> timeout
    for (int i = 0; i < 18; i++) step(0, 0, 4'b0000, 2'b10, 2'b01, 1, 0, 0);
    step(0, 0, 4'b0000, 2'b00, 2'b00, 0, 1, 0);
    dead_cycles(3, 1'b0, 4'b0000);
    for (int i = 0; i < 3; i++) step(0, 0, 4'b0000, 2'b00, 2'b00, 1, 0, 0);
    // Illegal command from RUN: error pulse, coast, IDLE
    step(0, 1, 4'b1000, 2'b10, 2'b10, 1, 0, 0);
    step(0, 1, 4'b1100, 2'b00, 2'b00, 0, 0, 1);
    dead_cycles(3, 1'b0, 4'b0000);
    step(0, 0, 4'b0000, 2'b00, 2'b00, 1, 0, 0);
    step(0, 0, 4'b0000, 2'b00, 2'b00, 1, 0, 0);
    // Reset during coast discards the stored target
    step(0, 1, 4'b1000, 2'b10, 2'b10, 1, 0, 0);
    step(0, 1, 4'b0100, 2'b00, 2'b00, 0, 0, 0);
    step(0, 0, 4'b0000, 2'b00, 2'b00, 0, 0, 0);
    step(1, 0, 4'b0000, 2'b00, 2'b00, 1, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 4'b0000, 2'b00, 2'b00, 1, 0, 0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/drive_sequencer.md
# drive_sequencer

- Sits between the remote-command decoder and the two DC motor channels (left and right wheel).
- Turns 4-bit drive commands into per-wheel `dir` codes: `2'b10` forward, `2'b01` backward, `2'b00` stop.
- Enforces a dead-time coast (both wheels stopped) before any moving wheel changes direction or stops.
- Forces a stop when no command arrives within a watchdog window.

## Interface
- `DEAD_CYCLES`, default 50000: coast length in clk cycles; must be ≥1.
- `WDOG_CYCLES`, default 5000000: command-silence limit in clk cycles while running; must be ≥2.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `cmd_valid`  in  1  command present.
- `cmd`  in  4  {fwd, bwd, left, right}, i.e. bit3 = fwd, bit0 = right.
- `cmd_ready`  out  1  command can be accepted; handshake is `cmd_valid & cmd_ready`.
- `dir_l`  out  2  left motor direction code.
- `dir_r`  out  2  right motor direction code.
- `timeout`  out  1  one-cycle pulse on watchdog expiry.
- `cmd_err`  out  1  one-cycle pulse on accepted illegal command.

## Operation
- Command map, written as cmd → dir_l/dir_r:
  - 1000 → 10/10
  - 0100 → 01/01
  - 0001 → 10/01
  - 0010 → 01/10
  - 1010 → 00/10
  - 1001 → 10/00
  - 0110 → 00/01
  - 0101 → 01/00
  - 0000 → 00/00
- Any other code is illegal:
  - `cmd_err` pulses the cycle after acceptance.
  - The command is treated as 0000.
- States:
  - IDLE: both outputs 00, ready = 1, watchdog held at 0.
  - RUN: outputs equal the current target, ready = 1, watchdog counting.
  - DEAD: both outputs 00, ready = 0, dead counter counting.
- Behaviour on an accepted command:
  - A wheel "leaves motion" when its current output is nonzero and its target differs (to 00 or the opposite direction).
  - If any wheel leaves motion: store the target, go to DEAD.
  - Otherwise, if the target is 00/00: stay in or go to IDLE.
  - Otherwise: go to RUN and apply the target. This covers an IDLE start and adding motion to an already-stopped wheel.
  - In every case the watchdog clears to 0.
- Re-sending the current command in RUN changes nothing except clearing the watchdog.
- DEAD exit:
  - After `DEAD_CYCLES` cycles in DEAD, apply the stored target.
  - Next state is RUN if the target is nonzero, IDLE if it is 00/00.
- Invariant: a wheel never goes from one nonzero code to a different code without at least `DEAD_CYCLES` consecutive 00 cycles in between.
- Watchdog:
  - Increments each cycle in RUN when no command is accepted.
  - On reaching `WDOG_CYCLES - 1`: `timeout` pulses next cycle, stored target becomes 00/00, state goes to DEAD.
- Counter widths: `$clog2` of the respective parameter + 1, with no wrap. Both counters clear on every state entry.
- Reset values: state IDLE, `dir_l` = 00, `dir_r` = 00, `cmd_ready` = 1, `timeout` = 0, `cmd_err` = 0, both counters 0, stored target 00/00.

## Timing
- All outputs are registered. A command accepted at edge N produces its effect from cycle N+1.
- Direct apply: new `dir_*` valid at N+1.
- DEAD path:
  - Outputs 00/00 and `cmd_ready` = 0 for cycles N+1 … N+DEAD_CYCLES.
  - Target and `cmd_ready` = 1 at N+DEAD_CYCLES+1.
- Watchdog path:
  - Last accept at N, no accept in N+1 … N+WDOG_CYCLES−1.
  - `timeout` high and outputs 00/00 at cycle N+WDOG_CYCLES.
  - Then the DEAD sequence runs, then IDLE.
- Simultaneous accept and watchdog terminal count: the accept wins, and the watchdog clears with no timeout.
- `cmd_valid` while in DEAD: not accepted. The upstream block must hold the command until `cmd_ready` is high.
- `rst` asserted in any state, including mid-DEAD: reset values at the next edge; the stored target is discarded.
- `cmd_err` and `timeout` are never high for more than one cycle per event.

## Test plan
Bench parameters: `DEAD_CYCLES` = 4, `WDOG_CYCLES` = 20.
- Reset, then accept 1000 at edge N → `dir_l`/`dir_r` = 10/10 at N+1, `cmd_ready` stays 1, state RUN.
- From 10/10, accept 0100 at M → 00/00 and ready = 0 during M+1 … M+4, then 01/01 and ready = 1 at M+5. Holding `cmd_valid` during M+1 … M+4 → no accept.
- From 00/10 (cmd 1010), accept 1000 → 10/10 next cycle with no DEAD. Then accept 1010 → DEAD for 4 cycles, then 00/10.
- Accept 0001, then idle 19 cycles → `timeout` pulses once with 00/00, 4 DEAD cycles, then IDLE with ready = 1. An accept at cycle 19 instead prevents the timeout.
- In RUN 10/10, accept 1100 → `cmd_err` one-cycle pulse, DEAD for 4 cycles, then IDLE 00/00.
- Assert `rst` at DEAD cycle 2 → 00/00, ready = 1, IDLE next cycle. The old target is never applied.
